life_gen_sched: RTL and testbench

//  Sequences one Life generation: raster-scans every board cell, hands each (x,y) to the rule

---
 rtl/life_gen_sched_if.sv | 31 +++
 rtl/life_gen_sched.sv | 186 ++++++++++++++++++
 tb/tb_life_gen_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_gen_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | life_gen_sched_if: rule-datapath handshake and board write port bundle  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface life_gen_sched_if #(
  parameter int AW = 8
);
  logic          eval_valid;
  logic          eval_ready;
  logic [AW-1:0] eval_x;
  logic [AW-1:0] eval_y;
  logic          res_valid;
  logic          res_alive;
  logic          wr_en;
  logic          wr_buf;
  logic [AW-1:0] wr_x;
  logic [AW-1:0] wr_y;
  logic          wr_data;

  modport master (
    output eval_valid, eval_x, eval_y, wr_en, wr_buf, wr_x, wr_y, wr_data,
    input  eval_ready, res_valid, res_alive
  );

  modport slave (
    input  eval_valid, eval_x, eval_y, wr_en, wr_buf, wr_x, wr_y, wr_data,
    output eval_ready, res_valid, res_alive
  );
endinterface
`default_nettype wire

// File: rtl/life_gen_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | life_gen_sched: raster-scans one Life generation into the next buffer,  |
// | swaps buffers, and services edit-mode cursor toggles.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module life_gen_sched #(
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8,
  parameter int AW         = 8,
  parameter int GEN_PERIOD = 25000000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          mode,
  input  wire logic          step_req,
  input  wire logic          toggle_req,
  input  wire logic [AW-1:0] cur_x,
  input  wire logic [AW-1:0] cur_y,
  input  wire logic          cell_at_cur,
  life_gen_sched_if.master   bus,
  output logic               rd_buf,
  output logic               busy,
  output logic [15:0]        gen_count
);

  localparam int PW = (GEN_PERIOD > 1) ? $clog2(GEN_PERIOD) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(GEN_PERIOD - 1);
  localparam logic [AW-1:0] X_LAST      = AW'(MAP_WIDTH - 1);
  localparam logic [AW-1:0] Y_LAST      = AW'(MAP_HEIGHT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_SWAP   = 3'd4;
  localparam logic [2:0] S_TOGGLE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          rd_buf_q, rd_buf_d;
  logic [15:0]   gen_count_q, gen_count_d;
  logic [AW-1:0] scan_x_q, scan_x_d;
  logic [AW-1:0] scan_y_q, scan_y_d;
  logic [PW-1:0] period_q, period_d;
  logic          step_pending_q, step_pending_d;
  logic          step_prev_q, step_prev_d;
  logic          toggle_prev_q, toggle_prev_d;
  logic          res_q, res_d;

  logic step_edge;
  logic toggle_edge;

  assign step_edge   = step_req & ~step_prev_q;
  assign toggle_edge = toggle_req & ~toggle_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rd_buf_q       <= 1'b0;
      gen_count_q    <= 16'd0;
      scan_x_q       <= '0;
      scan_y_q       <= '0;
      period_q       <= '0;
      step_pending_q <= 1'b0;
      step_prev_q    <= 1'b0;
      toggle_prev_q  <= 1'b0;
      res_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_buf_q       <= rd_buf_d;
      gen_count_q    <= gen_count_d;
      scan_x_q       <= scan_x_d;
      scan_y_q       <= scan_y_d;
      period_q       <= period_d;
      step_pending_q <= step_pending_d;
      step_prev_q    <= step_prev_d;
      toggle_prev_q  <= toggle_prev_d;
      res_q          <= res_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rd_buf_d       = rd_buf_q;
    gen_count_d    = gen_count_q;
    scan_x_d       = scan_x_q;
    scan_y_d       = scan_y_q;
    period_d       = '0;
    step_pending_d = step_pending_q;
    step_prev_d    = step_req;
    toggle_prev_d  = toggle_req;
    res_d          = res_q;
    case (state_q)
      S_IDLE: begin
        if (mode) begin
          if (period_q == PERIOD_LAST) begin
            state_d        = S_ISSUE;
            step_pending_d = 1'b0;
          end else begin
            period_d = period_q + 1'b1;
          end
        end else if (toggle_edge) begin
          // Toggle wins a tie; the step is remembered and runs right after.
          state_d = S_TOGGLE;
          if (step_edge) step_pending_d = 1'b1;
        end else if (step_edge || step_pending_q) begin
          state_d        = S_ISSUE;
          step_pending_d = 1'b0;
        end
      end
      S_TOGGLE: state_d = S_IDLE;
      S_ISSUE: begin
        if (bus.eval_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.res_valid) begin
          res_d   = bus.res_alive;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_ISSUE;
        if (scan_x_q == X_LAST) begin
          scan_x_d = '0;
          if (scan_y_q == Y_LAST) begin
            scan_y_d = '0;
            state_d  = S_SWAP;
          end else begin
            scan_y_d = scan_y_q + 1'b1;
          end
        end else begin
          scan_x_d = scan_x_q + 1'b1;
        end
      end
      S_SWAP: begin
        rd_buf_d    = ~rd_buf_q;
        gen_count_d = gen_count_q + 16'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.eval_valid = 1'b0;
    bus.eval_x     = '0;
    bus.eval_y     = '0;
    bus.wr_en      = 1'b0;
    bus.wr_buf     = 1'b0;
    bus.wr_x       = '0;
    bus.wr_y       = '0;
    bus.wr_data    = 1'b0;
    busy           = 1'b0;
    case (state_q)
      S_ISSUE: begin
        bus.eval_valid = 1'b1;
        bus.eval_x     = scan_x_q;
        bus.eval_y     = scan_y_q;
        busy           = 1'b1;
      end
      S_WAIT: busy = 1'b1;
      S_WRITE: begin
        bus.wr_en   = 1'b1;
        bus.wr_buf  = ~rd_buf_q;
        bus.wr_x    = scan_x_q;
        bus.wr_y    = scan_y_q;
        bus.wr_data = res_q;
        busy        = 1'b1;
      end
      S_SWAP: busy = 1'b1;
      S_TOGGLE: begin
        bus.wr_en   = 1'b1;
        bus.wr_buf  = rd_buf_q;
        bus.wr_x    = cur_x;
        bus.wr_y    = cur_y;
        bus.wr_data = ~cell_at_cur;
      end
      default: ;
    endcase
  end

  assign rd_buf    = rd_buf_q;
  assign gen_count = gen_count_q;

endmodule
`default_nettype wire

// File: tb/tb_life_gen_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_life_gen_sched: scoreboard bench for the generation scheduler        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_life_gen_sched;
  localparam int AW = 8;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int GP = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          step_req = 1'b0;
  logic          toggle_req = 1'b0;
  logic [AW-1:0] cur_x = '0;
  logic [AW-1:0] cur_y = '0;
  logic          cell_at_cur = 1'b0;
  logic          rd_buf;
  logic          busy;
  logic [15:0]   gen_count;

  life_gen_sched_if #(.AW(AW)) bus ();

  life_gen_sched #(
    .MAP_WIDTH(W), .MAP_HEIGHT(H), .AW(AW), .GEN_PERIOD(GP)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .step_req(step_req), .toggle_req(toggle_req),
    .cur_x(cur_x), .cur_y(cur_y), .cell_at_cur(cell_at_cur), .bus(bus),
    .rd_buf(rd_buf), .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          b;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic          d;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_a, mon_e;
  int   tests = 0;
  int   fails = 0;
  int   wr_seen = 0;
  logic exp_rd = 1'b0;
  int   exp_gen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every board write must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.wr_en === 1'b1) begin
      mon_a = '{bus.wr_buf, bus.wr_x, bus.wr_y, bus.wr_data};
      wr_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got %0h expected none", mon_a);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", 32'(mon_a), 32'(mon_e));
      end
    end
  end

  // Rule-datapath model: result one cycle after acceptance, alive = x[0].
  logic acc_q = 1'b0;
  logic acc_alive = 1'b0;
  logic stall_arm = 1'b0;
  int   stall_cnt = 0;

  initial begin
    bus.eval_ready = 1'b1;
    bus.res_valid  = 1'b0;
    bus.res_alive  = 1'b0;
  end

  always @(negedge clk) begin
    // A stray result while stalled in ISSUE must be ignored.
    bus.res_valid = acc_q | (stall_arm && stall_cnt == 2);
    bus.res_alive = acc_q ? acc_alive : 1'b1;
    if (stall_arm && stall_cnt > 0 && stall_cnt < 5) begin
      check("stall_hold", {29'd0, bus.eval_valid, bus.eval_x[0], bus.eval_y[0]} |
            {bus.eval_x, bus.eval_y, 16'd0}, {8'd2, 8'd1, 13'd0, 3'b101});
      bus.eval_ready = 1'b0;
      stall_cnt++;
    end else if (stall_arm && stall_cnt == 0 && bus.eval_valid === 1'b1 &&
                 bus.eval_x == 8'd2 && bus.eval_y == 8'd1) begin
      bus.eval_ready = 1'b0;
      stall_cnt = 1;
    end else begin
      bus.eval_ready = 1'b1;
    end
    acc_q     = (bus.eval_valid === 1'b1) && bus.eval_ready;
    acc_alive = bus.eval_x[0];
  end

  task automatic push_gen(input logic b, input int ncell);
    int k = 0;
    logic [AW-1:0] xv;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        xv = AW'(x);
        if (k < ncell) exp_q.push_back('{b, xv, AW'(y), xv[0]});
        k++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rd_buf"}, 32'(rd_buf), 0);
    check({name, "_gen_count"}, 32'(gen_count), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_eval"}, {bus.eval_valid, bus.eval_x, bus.eval_y}, 0);
    check({name, "_wr"}, {bus.wr_en, bus.wr_buf, bus.wr_x, bus.wr_y, bus.wr_data}, 0);
  endtask

  task automatic gen_step(input string name, input int exp_busy);
    int n = 0;
    int guard = 0;
    int base = wr_seen;
    push_gen(~exp_rd, W * H);
    step_req = 1'b1;
    while (guard < 1000) begin
      @(negedge clk);
      guard++;
      if (busy === 1'b1) n++;
      else if (n > 0) break;
      if (n == 50) toggle_req = 1'b1;
    end
    step_req   = 1'b0;
    toggle_req = 1'b0;
    exp_rd  = ~exp_rd;
    exp_gen = exp_gen + 1;
    check({name, "_busy_cycles"}, n, exp_busy);
    check({name, "_rd_buf"}, 32'(rd_buf), 32'(exp_rd));
    check({name, "_gen_count"}, 32'(gen_count), 32'(exp_gen & 16'hFFFF));
    check({name, "_writes"}, wr_seen - base, W * H);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int cyc = 0;
    while (busy !== lvl && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (busy !== lvl) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy got %b required %b", name, busy, lvl);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    int base;

    // Reset
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single toggle from a long button press
    cur_x = 8'd3; cur_y = 8'd3; cell_at_cur = 1'b0;
    base = wr_seen;
    exp_q.push_back('{1'b0, 8'd3, 8'd3, 1'b1});
    toggle_req = 1'b1;
    repeat (20) @(negedge clk);
    toggle_req = 1'b0;
    repeat (3) @(negedge clk);
    check("toggle_write_count", wr_seen - base, 1);

    // Edit-mode step, with a toggle press during busy that must be dropped
    gen_step("step1", 193);
    repeat (3) @(negedge clk);

    // Step with eval_ready held low at (2,1)
    stall_cnt = 0;
    stall_arm = 1'b1;
    gen_step("stall", 198);
    check("stall_cycles", stall_cnt, 5);
    stall_arm = 1'b0;
    repeat (3) @(negedge clk);

    // Run mode: two timed generations, then back to edit mid-generation
    push_gen(~exp_rd, W * H);
    push_gen(exp_rd, W * H);
    mode = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (bus.eval_valid === 1'b1) break;
    end
    check("run_first_latency", n, GP);
    wait_busy(1'b0, "run_gen1");
    n = 0;
    while (busy === 1'b0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("run_idle_gap", n, GP);
    mode = 1'b0;
    wait_busy(1'b0, "run_gen2");
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    check("run_stopped", n, 0);
    check("run_gen_count", 32'(gen_count), 4);
    check("run_rd_buf", 32'(rd_buf), 0);
    exp_rd = 1'b0;
    exp_gen = 4;

    // Toggle and step together, then reset at cell 20
    cur_x = 8'd5; cur_y = 8'd6; cell_at_cur = 1'b1;
    base = wr_seen;
    exp_q.push_back('{1'b0, 8'd5, 8'd6, 1'b0});
    push_gen(1'b1, 21);
    toggle_req = 1'b1;
    step_req   = 1'b1;
    n = 0;
    while (wr_seen < base + 22 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("combo_writes", wr_seen - base, 22);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midgen_reset");
    rst = 1'b0;
    toggle_req = 1'b0;
    step_req   = 1'b0;
    repeat (5) @(negedge clk);
    check("after_reset_idle", 32'(busy), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
